// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit for the EX stage: multi-cycle MULT/DIV,
// the HI/LO architectural registers and the MTxx/MFxx moves.
module hilo_muldiv_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_ITER   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mulE,
    input  logic        divE,
    input  logic        signE,
    input  logic        mthiE,
    input  logic        mtloE,
    input  logic        mfhiE,
    input  logic        mfloE,
    input  logic        cancelE,
    input  logic [31:0] AE,
    input  logic [31:0] BE,
    output logic [31:0] hi_loE,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     opA_q;
    logic [31:0]     opB_q;
    logic            sign_q;
    logic [32:0]     rem_q;
    logic [31:0]     quo_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            divZero_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;

    logic [63:0]     aExt_d;
    logic [63:0]     bExt_d;
    logic [63:0]     prod_d;
    logic [33:0]     trial_d;
    logic [31:0]     magA_d;
    logic [31:0]     magB_d;

    // Low 64 bits of the extended product are correct for both signednesses
    assign aExt_d  = {{32{sign_q & opA_q[31]}}, opA_q};
    assign bExt_d  = {{32{sign_q & opB_q[31]}}, opB_q};
    assign prod_d  = aExt_d * bExt_d;
    assign trial_d = {rem_q, quo_q[31]} - {2'b00, opB_q};
    assign magA_d  = (signE && AE[31]) ? -AE : AE;
    assign magB_d  = (signE && BE[31]) ? -BE : BE;

    assign busy      = (state_q != IDLE);
    assign stall_req = busy & (mulE | divE | mthiE | mtloE | mfhiE | mfloE);
    assign hi_loE    = mfhiE ? hi_q : (mfloE ? lo_q : 32'h0);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            sign_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mulE) begin
                        opA_q   <= AE;
                        opB_q   <= BE;
                        sign_q  <= signE;
                        cnt_q   <= CW'(MUL_CYCLES - 1);
                        state_q <= MUL;
                    end else if (divE) begin
                        quo_q     <= magA_d;
                        opB_q     <= magB_d;
                        qneg_q    <= signE & (AE[31] ^ BE[31]);
                        rneg_q    <= signE & AE[31];
                        divZero_q <= (BE == 32'h0);
                        rem_q     <= '0;
                        cnt_q     <= CW'(DIV_ITER - 1);
                        state_q   <= DIV;
                    end
                    if (mthiE) hi_q <= AE;
                    if (mtloE) lo_q <= AE;
                end
                MUL: begin
                    if (cancelE) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= prod_d;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    if (cancelE) begin
                        state_q <= IDLE;
                    end else begin
                        quo_q <= {quo_q[30:0], ~trial_d[33]};
                        rem_q <= trial_d[33] ? {rem_q[31:0], quo_q[31]} : trial_d[32:0];
                        if (cnt_q == '0) state_q <= FIX;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    if (!cancelE) begin
                        // Divide by zero leaves LO all ones regardless of signs
                        lo_q <= divZero_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_q : quo_q);
                        hi_q <= rneg_q ? -rem_q[31:0] : rem_q[31:0];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- EX-stage consumer of the mul/div/HI/LO control bundle issued by the ID/EX pipeline register.
- Runs multi-cycle signed/unsigned MULT and DIV, owns the HI and LO architectural registers, and serves MTHI/MTLO/MFHI/MFLO.
- Returns a stall request to the hazard unit while an operation is in flight, which drives the ID/EX stallE input.

Parameters:
MUL_CYCLES, 4, cycles from MULT issue edge to HI/LO update (>=1)
DIV_ITER, 32, restoring-divide iterations (one quotient bit per cycle; fixed at 32 for 32-bit operands)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mulE  in  1  MULT/MULTU issue (valid for one cycle per instruction)
divE  in  1  DIV/DIVU issue
signE  in  1  1 = signed operation, 0 = unsigned
mthiE  in  1  write HI from AE
mtloE  in  1  write LO from AE
mfhiE  in  1  read HI
mfloE  in  1  read LO
cancelE  in  1  abort in-flight operation (exception flush)
AE  in  32  operand rs / dividend / MTxx data
BE  in  32  operand rt / divisor
hi_loE  out  32  HI when mfhiE=1, LO when mfloE=1, otherwise 0 (combinational)
busy  out  1  operation in flight
stall_req  out  1  busy & (mulE | divE | mthiE | mtloE | mfhiE | mfloE) (combinational)
hi  out  32  current HI register
lo  out  32  current LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=LO=0, busy=0, counters=0, internal operand/accumulator registers=0. Takes effect mid-operation: the operation is discarded.
- State machine states: IDLE, MUL, DIV, FIX.
- IDLE + mulE at edge:
  - Latch A, B and signE.
  - Load counter with MUL_CYCLES-1.
  - Go to MUL. The 64-bit product is formed from the latched operands (sign-extended if signed).
- MUL: counter decrements each edge. At the edge where counter==0: {HI,LO} <= product, state -> IDLE.
  - Result is visible MUL_CYCLES cycles after the issue edge.
  - busy=1 for exactly MUL_CYCLES cycles.
- IDLE + divE at edge:
  - Latch |A| and |B| (magnitudes if signed, raw if unsigned), plus sign flags qneg = A[31]^B[31] and rneg = A[31] (signed only).
  - Clear the 33-bit remainder. Counter = DIV_ITER-1. State -> DIV.
- DIV: one restoring iteration per edge.
  - Shift {rem,quo} left 1 and trial-subtract the divisor.
  - If non-negative, keep the difference and set the quotient LSB; otherwise set LSB 0.
  - After DIV_ITER iterations, go to FIX.
- FIX (one cycle): apply signs. LO <= qneg ? -quo : quo; HI <= rneg ? -rem : rem. State -> IDLE.
  - Total DIV latency is 33 cycles; busy=1 for 33 cycles.
- Divide by zero (B==0, sampled at issue): still takes 33 cycles. Result is defined: LO=32'hFFFFFFFF, HI=A.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. The magnitude path is 33 bits wide, so there is no trap.
- mulE and divE both high: MULT wins; the DIV is ignored (illegal encoding).
- MTHI/MTLO in IDLE: HI/LO <= AE at the edge. Both may be high in the same cycle, and both registers are written.
- MF read in the same cycle as MT returns the old value; the next cycle returns the new value.
- Any mul/div/mt/mf request while busy=1:
  - stall_req=1, no state change from the request.
  - The ID/EX register stalls and re-presents the instruction.
  - The request is accepted on the first cycle busy=0.
- busy falls in the cycle after the HI/LO write edge. In that cycle a waiting MF reads the new value with stall_req=0.
- cancelE=1 while busy: state -> IDLE at the next edge; HI/LO unchanged. cancelE in IDLE has no effect.
- cancelE takes priority over a completion in the same edge: no HI/LO write.
- hi_loE: mfhiE has priority if both mf flags are set.

Test Plan:
1. Reset mid-DIV: issue DIV 100/7, assert rst_n=0 on the 10th busy cycle -> HI=LO=0, busy=0 immediately (asynchronous).
2. Signed MULT, A=0xFFFFFFFE (-2), B=3 -> after 4 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. Unsigned same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. Signed DIV, A=-7 (0xFFFFFFF9), B=2 -> busy 33 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
4. DIV by zero, A=0x12345678, B=0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
5. MFLO held during MULT 6*7 -> stall_req=1 for 4 cycles; next cycle hi_loE=42 with stall_req=0. MTHI 0xDEADBEEF then MFHI next cycle -> hi_loE=0xDEADBEEF.
6. cancelE on the 5th DIV cycle with HI=LO=0x11111111 preloaded -> busy=0 next cycle, HI/LO remain 0x11111111. A following MULT 2*3 -> LO=6.
